// File: rtl/stage_pipe_buf.sv
// ---------------------------------------------------------------------------
// stage_pipe_buf
//   Generic valid/ready buffer placed between two pipeline stages
//   (IFU->IDU, IDU->EXU, EXU->LSU, LSU->WBU). It carries one flattened stage
//   payload struct per entry through a DEPTH-entry circular queue, applies
//   backpressure upstream, and can be squashed in one cycle by flush_i
//   (for example on a pc redirect).
//
//   Timing contract:
//     - in_ready and out_valid are functions of registered occupancy and
//       flush_i only, so no ready/valid path runs combinationally through
//       the block.
//     - out_data is a mux of storage registers selected by the read
//       pointer. There is no bypass from in_data, so a push at edge N
//       becomes visible just after edge N (1 cycle minimum latency).
//     - DEPTH>=2 sustains one transfer per cycle. DEPTH=1 alternates
//       full/empty and so moves at most one item every 2 cycles.
//
// Parameters
//   DATA_W : payload width in bits (set to $bits of the carried struct)
//   DEPTH  : number of entries, >= 1, need not be a power of two
//   CNT_W  : occupancy counter width, derived from DEPTH
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush_i    in   synchronous squash of all entries and same-cycle input
//   in_valid   in   upstream payload valid
//   in_ready   out  buffer accepts this cycle
//   in_data    in   upstream payload
//   out_valid  out  head entry valid toward downstream
//   out_ready  in   downstream accepts
//   out_data   out  head entry payload
//   count      out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------

// One storage slot. Written only when selected by the write pointer on a
// completed push; cleared by reset and otherwise left untouched (a flush
// does not clear storage).
module stage_pipe_buf_entry #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    data_q <= '0;
      else if (we_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

module stage_pipe_buf #(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = 2,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  count
);

   // A single-entry buffer still needs a 1-bit pointer to be legal.
   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic push, pop;

   logic [DEPTH-1:0]             entry_we;
   logic [DEPTH-1:0][DATA_W-1:0] entry_q;

   // Explicit wrap compare: DEPTH may be a non-power-of-two, so natural
   // pointer overflow cannot be relied on.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // ------------------------------------------------------------------
   // Handshake. Both sides are blocked during a flush, so the squashed
   // cycle neither consumes upstream data nor hands out a stale head.
   // ------------------------------------------------------------------
   assign in_ready  = (count_q != CNT_FULL) & ~flush_i;
   assign out_valid = (count_q != '0)       & ~flush_i;
   assign push      = in_valid  & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_q;

   // ------------------------------------------------------------------
   // Storage: one slot per entry, write-enabled by the write pointer.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign entry_we[i] = push & (wr_ptr_q == PTR_W'(i));

      stage_pipe_buf_entry #(
         .DATA_W (DATA_W)
      ) u_entry (
         .clk   (clk),
         .rst_n (rst_n),
         .we_i  (entry_we[i]),
         .d_i   (in_data),
         .q_o   (entry_q[i])
      );
   end

   // Head read: a register mux only, no path from in_data.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_ptr_q == PTR_W'(i)) out_data = entry_q[i];
      end
   end

   // ------------------------------------------------------------------
   // Pointer / occupancy next state. Flush wins over everything and
   // rewinds both pointers so the queue restarts from slot 0.
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Simulation checks. The history registers below only feed assertions
   // and are dropped by synthesis.
   // ------------------------------------------------------------------
   logic              chk_in_stall_q;
   logic [DATA_W-1:0] chk_in_data_q;
   logic              chk_out_stall_q;
   logic [DATA_W-1:0] chk_out_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_in_stall_q  <= 1'b0;
         chk_in_data_q   <= '0;
         chk_out_stall_q <= 1'b0;
         chk_out_data_q  <= '0;
      end else begin
         chk_in_stall_q  <= in_valid & ~in_ready;
         chk_in_data_q   <= in_data;
         chk_out_stall_q <= out_valid & ~out_ready & ~flush_i;
         chk_out_data_q  <= out_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_count_range: assert (count_q <= CNT_FULL)
            else $error("stage_pipe_buf: count above DEPTH");
         a_no_push_full: assert (!(push && (count_q == CNT_FULL)))
            else $error("stage_pipe_buf: push while full");
         a_no_pop_empty: assert (!(pop && (count_q == '0)))
            else $error("stage_pipe_buf: pop while empty");
         a_out_valid_known: assert (!$isunknown(out_valid))
            else $error("stage_pipe_buf: out_valid unknown");
         // Upstream must hold its payload while stalled.
         a_in_hold: assert (!(chk_in_stall_q && in_valid) || (in_data == chk_in_data_q))
            else $error("stage_pipe_buf: in_data changed while stalled");
         // A stalled head must not move unless squashed.
         a_out_hold: assert (!(chk_out_stall_q && !flush_i) ||
                             (out_valid && (out_data == chk_out_data_q)))
            else $error("stage_pipe_buf: head changed while stalled");
      end
   end

endmodule

// File: tb/tb_stage_pipe_buf.sv
module tb_stage_pipe_buf;

   localparam int NI = 4;
   localparam int DW = 16;
   localparam int XW = DW + 5;   // {in_ready, out_valid, count[2:0], data}

   // Instance k: 0 -> DEPTH 2, 1 -> DEPTH 4, 2 -> DEPTH 3, 3 -> DEPTH 1
   function automatic int dep_of(input int g);
      case (g)
         0:       return 2;
         1:       return 4;
         2:       return 3;
         default: return 1;
      endcase
   endfunction

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [NI-1:0]         vin, ordy, fl, irdy, oval;
   logic [NI-1:0][DW-1:0] din, dout;
   logic [NI-1:0][2:0]    cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model: the occupied entries in arrival order.
   logic [DW-1:0] mq[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = dep_of(g);
      logic [$clog2(D+1)-1:0] c;

      stage_pipe_buf #(
         .DATA_W (DW),
         .DEPTH  (D)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush_i   (fl[g]),
         .in_valid  (vin[g]),
         .in_ready  (irdy[g]),
         .in_data   (din[g]),
         .out_valid (oval[g]),
         .out_ready (ordy[g]),
         .out_data  (dout[g]),
         .count     (c)
      );

      assign cnt[g] = 3'(c);
   end

   // ---------------- reference model ----------------
   function automatic bit m_rdy(input int k, input bit f);
      return (mq.size() != dep_of(k)) && !f;
   endfunction

   function automatic bit m_val(input bit f);
      return (mq.size() != 0) && !f;
   endfunction

   function automatic logic [XW-1:0] m_exp(input int k);
      bit f;
      f = fl[k];
      return {m_rdy(k, f), m_val(f), 3'(mq.size()), m_val(f) ? mq[0] : {DW{1'b0}}};
   endfunction

   function automatic logic [XW-1:0] dut_obs(input int k);
      return {irdy[k], oval[k], cnt[k], oval[k] ? dout[k] : {DW{1'b0}}};
   endfunction

   // Advance one clock and apply the handshakes the model says complete.
   task automatic tick(input int k);
      bit f, psh, pp;
      logic [DW-1:0] d;
      f   = fl[k];
      psh = vin[k] && m_rdy(k, f);
      pp  = ordy[k] && m_val(f);
      d   = din[k];
      @(posedge clk); #1;
      if (f) mq.delete();
      else begin
         if (pp)  void'(mq.pop_front());
         if (psh) mq.push_back(d);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      for (int k = 0; k < NI; k++) begin
         checks++;
         if ({irdy[k], oval[k], cnt[k], dout[k]} !== {1'b1, 1'b0, 3'd0, {DW{1'b0}}}) begin
            failures++;
            $display("FAIL reset_state inst=%0d got rdy=%b val=%b cnt=%0d data=%h exp rdy=1 val=0 cnt=0 data=0",
                     k, irdy[k], oval[k], cnt[k], dout[k]);
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midstream();
      logic [XW-1:0] e, o;
      int k = 0;
      logic [DW-1:0] seq[3] = '{16'h000A, 16'h000B, 16'h000C};
      ordy[k] = 1'b0;
      vin[k]  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         din[k] = seq[i]; #1;
         e = m_exp(k); o = dut_obs(k); checks++;
         if (o !== e) begin failures++; $display("FAIL rst_mid_fill i=%0d got=%h exp=%h", i, o, e); end
         tick(k);
      end
      vin[k] = 1'b0;
      #2 rst_n = 1'b0;  // between edges
      #1;
      checks++;
      if ({irdy[k], oval[k], cnt[k]} !== {1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL rst_mid_async got rdy=%b val=%b cnt=%0d exp rdy=1 val=0 cnt=0", irdy[k], oval[k], cnt[k]);
      end
      mq.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      vin[k] = 1'b1; din[k] = seq[2]; #1;
      e = m_exp(k); o = dut_obs(k); checks++;
      if (o !== e) begin failures++; $display("FAIL rst_mid_push got=%h exp=%h", o, e); end
      tick(k);
      vin[k] = 1'b0; #1;
      checks++;
      if (oval[k] !== 1'b1 || dout[k] !== 16'h000C) begin
         failures++;
         $display("FAIL rst_mid_first got val=%b data=%h exp val=1 data=000c", oval[k], dout[k]);
      end
      ordy[k] = 1'b1;
      tick(k);
      ordy[k] = 1'b0; #1;
      e = m_exp(k); o = dut_obs(k); checks++;
      if (o !== e) begin failures++; $display("FAIL rst_mid_drain got=%h exp=%h", o, e); end
   endtask

   task automatic test_stream();
      logic [XW-1:0] e, o;
      int k = 0;
      ordy[k] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         vin[k] = (i <= 8);
         din[k] = (i <= 8) ? DW'(i) : '0;
         #1;
         e = m_exp(k); o = dut_obs(k); checks++;
         if (o !== e) begin failures++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, o, e); end
         // Steady state: one in flight, head is the previous push.
         if (i >= 2 && i <= 8) begin
            checks++;
            if (cnt[k] !== 3'd1 || dout[k] !== DW'(i - 1)) begin
               failures++;
               $display("FAIL stream_steady cyc=%0d got cnt=%0d data=%h exp cnt=1 data=%h", i, cnt[k], dout[k], DW'(i - 1));
            end
         end
         tick(k);
      end
      vin[k] = 1'b0; ordy[k] = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [XW-1:0] e, o;
      logic [DW-1:0] items[3] = '{16'h0011, 16'h0022, 16'h0033};
      int k = 0, idx = 0;
      bit acc;
      for (int c = 0; c < 14; c++) begin
         ordy[k] = (c >= 4);
         vin[k]  = (idx < 3);
         din[k]  = (idx < 3) ? items[idx] : '0;
         #1;
         e = m_exp(k); o = dut_obs(k); checks++;
         if (o !== e) begin failures++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, o, e); end
         acc = vin[k] && m_rdy(k, 1'b0);
         tick(k);
         if (acc) idx++;
      end
      checks++;
      if (idx != 3 || cnt[k] !== 3'd0) begin
         failures++;
         $display("FAIL backpressure_end got pushed=%0d cnt=%0d exp pushed=3 cnt=0", idx, cnt[k]);
      end
      vin[k] = 1'b0; ordy[k] = 1'b0;
   endtask

   task automatic test_flush();
      logic [XW-1:0] e, o;
      int k = 1;
      ordy[k] = 1'b0;
      vin[k]  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din[k] = DW'(16'h0041 + i); #1;
         e = m_exp(k); o = dut_obs(k); checks++;
         if (o !== e) begin failures++; $display("FAIL flush_fill i=%0d got=%h exp=%h", i, o, e); end
         tick(k);
      end
      fl[k] = 1'b1; din[k] = 16'h0044; #1;
      checks++;
      if (irdy[k] !== 1'b0 || oval[k] !== 1'b0) begin
         failures++;
         $display("FAIL flush_cycle got rdy=%b val=%b exp rdy=0 val=0", irdy[k], oval[k]);
      end
      tick(k);
      fl[k] = 1'b0; #1;
      e = m_exp(k); o = dut_obs(k); checks++;
      if (o !== e) begin failures++; $display("FAIL flush_after got=%h exp=%h", o, e); end
      tick(k);
      vin[k] = 1'b0; #1;
      checks++;
      if ({oval[k], cnt[k], dout[k]} !== {1'b1, 3'd1, 16'h0044}) begin
         failures++;
         $display("FAIL flush_repush got val=%b cnt=%0d data=%h exp val=1 cnt=1 data=0044", oval[k], cnt[k], dout[k]);
      end
      ordy[k] = 1'b1;
      tick(k);
      ordy[k] = 1'b0;
   endtask

   task automatic test_wrap();
      logic [XW-1:0] e, o;
      logic [DW-1:0] items[10];
      int k = 2, idx = 0, c = 0;
      bit acc;
      for (int i = 0; i < 10; i++) items[i] = DW'($urandom);
      while ((idx < 10 || mq.size() != 0) && c < 200) begin
         vin[k]  = (idx < 10) && ($urandom_range(0, 3) != 0);
         din[k]  = (idx < 10) ? items[idx] : '0;
         ordy[k] = 1'($urandom_range(0, 1));
         #1;
         e = m_exp(k); o = dut_obs(k); checks++;
         if (o !== e) begin failures++; $display("FAIL wrap cyc=%0d got=%h exp=%h", c, o, e); end
         acc = vin[k] && m_rdy(k, 1'b0);
         tick(k);
         if (acc) idx++;
         c++;
      end
      checks++;
      if (idx != 10 || mq.size() != 0) begin
         failures++;
         $display("FAIL wrap_budget got pushed=%0d left=%0d exp pushed=10 left=0", idx, mq.size());
      end
      vin[k] = 1'b0; ordy[k] = 1'b0;
   endtask

   task automatic test_depth1();
      logic [XW-1:0] e, o;
      logic [7:0] rdy_h = '0, val_h = '0;
      int k = 3, idx = 0;
      bit acc;
      ordy[k] = 1'b1;
      for (int c = 0; c < 9; c++) begin
         vin[k] = (idx < 4);
         din[k] = (idx < 4) ? DW'(16'h00D0 + idx) : '0;
         #1;
         e = m_exp(k); o = dut_obs(k); checks++;
         if (o !== e) begin failures++; $display("FAIL depth1 cyc=%0d got=%h exp=%h", c, o, e); end
         if (c < 8) begin
            rdy_h = {rdy_h[6:0], irdy[k]};
            val_h = {val_h[6:0], oval[k]};
         end
         acc = vin[k] && m_rdy(k, 1'b0);
         tick(k);
         if (acc) idx++;
      end
      checks++;
      if (rdy_h !== 8'b1010_1010 || val_h !== 8'b0101_0101) begin
         failures++;
         $display("FAIL depth1_rate got rdy=%b val=%b exp rdy=10101010 val=01010101", rdy_h, val_h);
      end
      vin[k] = 1'b0; ordy[k] = 1'b0;
   endtask

   task automatic test_random_flush();
      logic [XW-1:0] e, o;
      int k = 1;
      bit acc;
      logic [DW-1:0] cur;
      cur = DW'($urandom);
      for (int c = 0; c < 300; c++) begin
         vin[k]  = 1'($urandom_range(0, 3) != 0);
         din[k]  = cur;
         ordy[k] = 1'($urandom_range(0, 2) != 0);
         fl[k]   = ($urandom_range(0, 11) == 0);
         #1;
         e = m_exp(k); o = dut_obs(k); checks++;
         if (o !== e) begin failures++; $display("FAIL rand_flush cyc=%0d got=%h exp=%h", c, o, e); end
         acc = vin[k] && m_rdy(k, fl[k]);
         tick(k);
         if (acc) cur = DW'($urandom);
      end
      vin[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
      repeat (5) tick(k);
      ordy[k] = 1'b0;
   endtask

   initial begin
      vin = '0; ordy = '0; fl = '0; din = '0;
      test_reset();
      test_reset_midstream();
      test_stream();
      test_backpressure();
      test_flush();
      test_wrap();
      test_depth1();
      test_random_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
